// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared types, default constants and two-digit BCD helpers for the
// whack-a-mole game controller.
//   game_state_t      : controller state encoding (IDLE, COUNTDOWN, PLAY, OVER)
//   *_DEF             : default parameter values for game_sequencer
//   MOLE_W            : number of moles / buttons
//   bcd2_inc/bcd2_dec : one-step BCD increment / decrement with digit carry
//   to_bcd2           : converts a small integer (0-99) to two BCD digits
// -----------------------------------------------------------------------------
package game_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COUNTDOWN = 2'd1,
        PLAY      = 2'd2,
        OVER      = 2'd3
    } game_state_t;

    localparam int         COUNTDOWN_SEC_DEF = 5;
    localparam int         GAME_SEC_DEF      = 30;
    localparam logic [7:0] SCORE_MAX_DEF     = 8'h99;
    localparam int         MOLE_W            = 5;

    // Units 9 -> 0 carries into the tens digit; tens 9 wraps to 0.
    function automatic logic [7:0] bcd2_inc(input logic [7:0] v);
        logic [3:0] tens;
        logic [3:0] units;
        tens  = v[7:4];
        units = v[3:0];
        if (units == 4'd9) begin
            units = 4'd0;
            tens  = (tens == 4'd9) ? 4'd0 : tens + 4'd1;
        end else begin
            units = units + 4'd1;
        end
        return {tens, units};
    endfunction

    // Units 0 -> 9 borrows from the tens digit; tens 0 wraps to 9.
    function automatic logic [7:0] bcd2_dec(input logic [7:0] v);
        logic [3:0] tens;
        logic [3:0] units;
        tens  = v[7:4];
        units = v[3:0];
        if (units == 4'd0) begin
            units = 4'd9;
            tens  = (tens == 4'd0) ? 4'd9 : tens - 4'd1;
        end else begin
            units = units - 4'd1;
        end
        return {tens, units};
    endfunction

    function automatic logic [7:0] to_bcd2(input int n);
        logic [3:0] tens;
        logic [3:0] units;
        tens  = 4'((n / 10) % 10);
        units = 4'(n % 10);
        return {tens, units};
    endfunction

endpackage

// File: rtl/game_sequencer_bcd2_counter.sv
// -----------------------------------------------------------------------------
// bcd2_counter
// Two-digit BCD up/down counter with load. Priority: load, then inc, then dec.
// Increment saturates at MAX_VAL; decrement floors at 00.
// Ports:
//   clk        : system clock
//   reset      : asynchronous active-low reset (clears value to 00)
//   i_load     : load i_load_val
//   i_load_val : BCD value to load
//   i_inc      : increment by one (held at MAX_VAL)
//   i_dec      : decrement by one (held at 00)
//   o_value    : current BCD value
// -----------------------------------------------------------------------------
module bcd2_counter
    import game_pkg::*;
#(
    parameter logic [7:0] MAX_VAL = 8'h99
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_load,
    input  logic [7:0] i_load_val,
    input  logic       i_inc,
    input  logic       i_dec,
    output logic [7:0] o_value
);

    logic [7:0] r_value;

    // BCD digit order matches binary order, so a plain compare is a valid
    // magnitude test for the saturation check.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_value <= 8'h00;
        end else if (i_load) begin
            r_value <= i_load_val;
        end else if (i_inc) begin
            if (r_value < MAX_VAL) begin
                r_value <= bcd2_inc(r_value);
            end
        end else if (i_dec) begin
            if (r_value != 8'h00) begin
                r_value <= bcd2_dec(r_value);
            end
        end
    end

    assign o_value = r_value;

endmodule

// File: rtl/game_sequencer.sv
// -----------------------------------------------------------------------------
// game_sequencer
// Whack-a-mole game controller: pre-game countdown, timed play window, hit
// detection, BCD scoring and the packed display value, paced by a 1 Hz enable.
// Optional feature macro: MISS_PENALTY_EN -- when defined, a button edge on an
// unlit mole in PLAY (with no scoring hit that cycle) costs one point, floored
// at 00. When undefined the score only ever increments.
// Ports:
//   clk        : system clock (100 MHz)
//   reset      : asynchronous active-low reset
//   tick_1hz   : one-clk enable pulse once per second
//   start      : debounced start level; only a 0->1 edge is acted on
//   button_db  : debounced mole buttons
//   mole       : lit mole LEDs (one-hot or zero)
//   game_begin : high in PLAY
//   game_over  : high in OVER
//   hit_pulse  : one-clk pulse per scored hit
//   score_bcd  : two-digit BCD score
//   time_bcd   : two-digit BCD seconds remaining
//   disp_value : packed BCD value for the display controller
//   dbg_state  : current controller state (game_state_t encoding)
// -----------------------------------------------------------------------------
module game_sequencer
    import game_pkg::*;
#(
    parameter int         COUNTDOWN_SEC = COUNTDOWN_SEC_DEF,
    parameter int         GAME_SEC      = GAME_SEC_DEF,
    parameter logic [7:0] SCORE_MAX     = SCORE_MAX_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick_1hz,
    input  logic              start,
    input  logic [MOLE_W-1:0] button_db,
    input  logic [MOLE_W-1:0] mole,
    output logic              game_begin,
    output logic              game_over,
    output logic              hit_pulse,
    output logic [7:0]        score_bcd,
    output logic [7:0]        time_bcd,
    output logic [31:0]       disp_value,
    output logic [1:0]        dbg_state
);

    localparam logic [7:0] COUNTDOWN_BCD = to_bcd2(COUNTDOWN_SEC);
    localparam logic [7:0] GAME_BCD      = to_bcd2(GAME_SEC);

    game_state_t       r_state;
    logic              r_start_q;
    logic [MOLE_W-1:0] r_button_q;
    logic [MOLE_W-1:0] r_mole_q;
    logic              r_armed;
    logic              r_hit_pulse;

    logic              w_start_rise;
    logic [MOLE_W-1:0] w_button_rise;
    logic              w_time_is_one;
    logic              w_last_tick;
    logic              w_enter_play;
    logic              w_hit;
    logic              w_miss;
    logic              w_time_load;
    logic [7:0]        w_time_load_val;
    logic              w_time_dec;
    logic              w_score_load;
    logic [7:0]        w_score;
    logic [7:0]        w_time;

    assign w_start_rise  = start & ~r_start_q;
    assign w_button_rise = button_db & ~r_button_q;
    assign w_time_is_one = (w_time == 8'h01);
    assign w_last_tick   = tick_1hz & w_time_is_one;
    assign w_enter_play  = (r_state == COUNTDOWN) && w_last_tick;

    // Multiple matching edges in one cycle reduce to a single hit.
    assign w_hit = (r_state == PLAY) && r_armed && (|(w_button_rise & mole));

`ifdef MISS_PENALTY_EN
    assign w_miss = (r_state == PLAY) && (|(w_button_rise & ~mole)) && !w_hit;
`else
    assign w_miss = 1'b0;
`endif

    // Time counter control: load on state entry, otherwise count down per tick.
    always_comb begin
        w_time_load     = 1'b0;
        w_time_load_val = 8'h00;
        w_time_dec      = 1'b0;
        case (r_state)
            IDLE, OVER: begin
                if (w_start_rise) begin
                    w_time_load     = 1'b1;
                    w_time_load_val = COUNTDOWN_BCD;
                end
            end
            COUNTDOWN: begin
                if (w_last_tick) begin
                    w_time_load     = 1'b1;
                    w_time_load_val = GAME_BCD;
                end else if (tick_1hz) begin
                    w_time_dec = 1'b1;
                end
            end
            PLAY: begin
                // The 01 -> 00 step is the ordinary floored decrement.
                w_time_dec = tick_1hz;
            end
            default: begin
                w_time_load = 1'b0;
            end
        endcase
    end

    assign w_score_load = ((r_state == IDLE) || (r_state == OVER)) && w_start_rise;

    bcd2_counter #(
        .MAX_VAL (SCORE_MAX)
    ) u_score (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_score_load),
        .i_load_val (8'h00),
        .i_inc      (w_hit),
        .i_dec      (w_miss),
        .o_value    (w_score)
    );

    bcd2_counter #(
        .MAX_VAL (8'h99)
    ) u_time (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_time_load),
        .i_load_val (w_time_load_val),
        .i_inc      (1'b0),
        .i_dec      (w_time_dec),
        .o_value    (w_time)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_start_q   <= 1'b0;
            r_button_q  <= '0;
            r_mole_q    <= '0;
            r_armed     <= 1'b0;
            r_hit_pulse <= 1'b0;
        end else begin
            r_start_q   <= start;
            r_button_q  <= button_db;
            r_mole_q    <= mole;
            r_hit_pulse <= w_hit;

            // A new mole appearing in the same cycle as a hit re-arms:
            // the hit consumed the old mole, the new one is still fair game.
            if (w_enter_play || (mole != r_mole_q)) begin
                r_armed <= 1'b1;
            end else if (w_hit) begin
                r_armed <= 1'b0;
            end

            case (r_state)
                IDLE, OVER: begin
                    if (w_start_rise) begin
                        r_state <= COUNTDOWN;
                    end
                end
                COUNTDOWN: begin
                    if (w_last_tick) begin
                        r_state <= PLAY;
                    end
                end
                PLAY: begin
                    if (w_last_tick) begin
                        r_state <= OVER;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Display mux is combinational so it tracks the counters with no extra stage.
    always_comb begin
        disp_value = 32'h0;
        case (r_state)
            COUNTDOWN: disp_value = {24'h0, w_time};
            PLAY:      disp_value = {16'h0, w_time, w_score};
            OVER:      disp_value = {24'h0, w_score};
            default:   disp_value = 32'h0;
        endcase
    end

    assign game_begin = (r_state == PLAY);
    assign game_over  = (r_state == OVER);
    assign hit_pulse  = r_hit_pulse;
    assign score_bcd  = w_score;
    assign time_bcd   = w_time;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_game_sequencer.sv
// -----------------------------------------------------------------------------
// tb_game_sequencer
// Directed bench for game_sequencer with default parameters (5 s countdown,
// 30 s game, score saturating at 99). Inputs change on the falling clock edge,
// outputs are checked on the following falling edge.
// -----------------------------------------------------------------------------
module tb_game_sequencer;
    import game_pkg::*;

    logic        clk;
    logic        reset;
    logic        tick_1hz;
    logic        start;
    logic [4:0]  button_db;
    logic [4:0]  mole;
    logic        game_begin;
    logic        game_over;
    logic        hit_pulse;
    logic [7:0]  score_bcd;
    logic [7:0]  time_bcd;
    logic [31:0] disp_value;
    logic [1:0]  dbg_state;

    int n_vec;
    int n_err;
    int exp_score;

    game_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .tick_1hz   (tick_1hz),
        .start      (start),
        .button_db  (button_db),
        .mole       (mole),
        .game_begin (game_begin),
        .game_over  (game_over),
        .hit_pulse  (hit_pulse),
        .score_bcd  (score_bcd),
        .time_bcd   (time_bcd),
        .disp_value (disp_value),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] bcd(input int n);
        return 8'((n / 10) * 16 + (n % 10));
    endfunction

    // ---------------- drivers ----------------
    task automatic do_tick();
        @(negedge clk);
        tick_1hz = 1'b1;
        @(negedge clk);
        tick_1hz = 1'b0;
    endtask

    task automatic start_game();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic press(input string tag, input logic [4:0] pat,
                         input logic exp_hit, input logic [7:0] exp_sc);
        @(negedge clk);
        button_db = pat;
        @(negedge clk);
        check({tag, "_pulse"}, 32'(hit_pulse), 32'(exp_hit));
        check({tag, "_score"}, 32'(score_bcd), 32'(exp_sc));
        button_db = 5'b0;
        @(negedge clk);
        check({tag, "_pulse_off"}, 32'(hit_pulse), 32'h0);
    endtask

    // Light a different mole (re-arms), then hit it.
    task automatic hit_next(input string tag);
        @(negedge clk);
        mole = (mole == 5'b00100) ? 5'b01000 : 5'b00100;
        if (exp_score < 99) exp_score++;
        press(tag, mole, 1'b1, bcd(exp_score));
    endtask

    task automatic countdown_to_play();
        start_game();
        check("cd_state", 32'(dbg_state), 32'(COUNTDOWN));
        check("cd_time5", 32'(time_bcd), 32'h05);
        check("cd_disp", disp_value, 32'h0000_0005);
        for (int i = 4; i >= 1; i--) begin
            do_tick();
            check("cd_time", 32'(time_bcd), 32'(bcd(i)));
        end
        do_tick();
        check("play_begin", 32'(game_begin), 32'h1);
        check("play_time30", 32'(time_bcd), 32'h30);
        check("play_disp", disp_value, 32'h0000_3000);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_vec     = 0;
        n_err     = 0;
        exp_score = 0;
        reset     = 1'b0;
        tick_1hz  = 1'b0;
        start     = 1'b0;
        button_db = 5'b0;
        mole      = 5'b0;

        repeat (2) @(negedge clk);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        check("rst_score", 32'(score_bcd), 32'h0);
        check("rst_time", 32'(time_bcd), 32'h0);
        check("rst_disp", disp_value, 32'h0);
        check("rst_outs", {29'h0, game_begin, game_over, hit_pulse}, 32'h0);
        reset = 1'b1;

        // Button edges outside PLAY are ignored.
        mole = 5'b00100;
        press("idle_btn", 5'b00100, 1'b0, 8'h00);

        // ---- game 1 ----
        countdown_to_play();

        // Start edge during PLAY is ignored.
        start_game();
        check("play_start_ign", 32'(dbg_state), 32'(PLAY));
        check("play_start_time", 32'(time_bcd), 32'h30);

        press("hit1", 5'b00100, 1'b1, 8'h01);
        press("rehit_noarm", 5'b00100, 1'b0, 8'h01);
        @(negedge clk);
        mole = 5'b01000;
        press("hit2", 5'b01000, 1'b1, 8'h02);
        @(negedge clk);
        mole = 5'b00001;
        press("hit3", 5'b00001, 1'b1, 8'h03);

`ifdef MISS_PENALTY_EN
        press("miss1", 5'b10000, 1'b0, 8'h02);
        press("miss2", 5'b10000, 1'b0, 8'h01);
        press("miss3", 5'b10000, 1'b0, 8'h00);
        press("miss_floor", 5'b10000, 1'b0, 8'h00);
        exp_score = 0;
`else
        press("miss_ignored", 5'b10000, 1'b0, 8'h03);
        exp_score = 3;
`endif

        // All buttons rise at once on a lit mole: exactly one point.
        @(negedge clk);
        mole = 5'b00010;
        exp_score++;
        press("multi_edge", 5'b11111, 1'b1, bcd(exp_score));

        while (exp_score < 9) hit_next("climb9");
        check("score_09", 32'(score_bcd), 32'h09);
        @(negedge clk);
        mole = 5'b10000;
        exp_score++;
        press("carry_09_10", 5'b10000, 1'b1, 8'h10);

        // Tick down 30 -> 01, checking every BCD step (incl. borrow 30 -> 29).
        for (int t = 29; t >= 1; t--) begin
            do_tick();
            check("play_time", 32'(time_bcd), 32'(bcd(t)));
        end
        check("play_disp_late", disp_value, 32'h0000_0110);

        // Hit coincident with the final tick still counts.
        @(negedge clk);
        mole = 5'b00001;
        @(negedge clk);
        button_db = 5'b00001;
        tick_1hz  = 1'b1;
        @(negedge clk);
        button_db = 5'b0;
        tick_1hz  = 1'b0;
        check("final_state", 32'(dbg_state), 32'(OVER));
        check("final_over", {30'h0, game_over, game_begin}, 32'h2);
        check("final_score", 32'(score_bcd), 32'h11);
        check("final_pulse", 32'(hit_pulse), 32'h1);
        check("final_time", 32'(time_bcd), 32'h00);
        check("final_disp", disp_value, 32'h0000_0011);
        do_tick();
        check("over_hold", 32'(score_bcd), 32'h11);

        // ---- game 2: restart from OVER with start held high ----
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        check("restart_state", 32'(dbg_state), 32'(COUNTDOWN));
        check("restart_score", 32'(score_bcd), 32'h00);
        check("restart_time", 32'(time_bcd), 32'h05);
        do_tick();
        repeat (3) @(negedge clk);
        check("held_start_time", 32'(time_bcd), 32'h04);
        check("held_start_state", 32'(dbg_state), 32'(COUNTDOWN));
        start = 1'b0;
        for (int i = 3; i >= 1; i--) do_tick();
        do_tick();
        check("g2_play", 32'(dbg_state), 32'(PLAY));
        exp_score = 0;
        repeat (7) hit_next("g2_hit");
        check("g2_score07", 32'(score_bcd), 32'h07);

        // Asynchronous reset mid-PLAY, observed before the next rising edge.
        #2 reset = 1'b0;
        #1;
        check("async_rst_state", 32'(dbg_state), 32'(IDLE));
        check("async_rst_score", 32'(score_bcd), 32'h00);
        check("async_rst_disp", disp_value, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // ---- game 3: saturation ----
        countdown_to_play();
        exp_score = 0;
        while (exp_score < 99) hit_next("g3_hit");
        check("score_99", 32'(score_bcd), 32'h99);
        @(negedge clk);
        mole = 5'b00010;
        press("sat_99", 5'b00010, 1'b1, 8'h99);
        check("sat_disp", disp_value, 32'h0000_3099);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
